// File: rtl/memory_access.sv
// MEM stage: byte/half/word loads and stores on a private little-endian data RAM, feeding MEM/WB.
// Optional MEM_DEBUG_PORT_EN adds a combinational word-read port (i_dbg_addr -> o_dbg_data).
module memory_access #(
  parameter int NB_DATA  = 32,
  parameter int NB_WADDR = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_halt,
  input  logic                i_ctl_MEM_mem_read,
  input  logic                i_ctl_MEM_mem_write,
  input  logic                i_ctl_MEM_unsigned,
  input  logic [1:0]          i_ctl_MEM_data_width,
  input  logic                i_ctl_WB_mem_to_reg,
  input  logic                i_ctl_WB_reg_write,
  input  logic [NB_DATA-1:0]  i_ALU_result,
  input  logic [NB_DATA-1:0]  i_data_to_write,
  input  logic [4:0]          i_reg_dest,
  output logic                o_ctl_WB_mem_to_reg,
  output logic                o_ctl_WB_reg_write,
  output logic [NB_DATA-1:0]  o_read_data,
  output logic [NB_DATA-1:0]  o_ALU_result,
  output logic [4:0]          o_reg_dest,
  output logic                o_misaligned,
  output logic [NB_DATA-1:0]  o_MEM_ALU_result_wire,
  output logic [4:0]          o_MEM_reg_dest_wire
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_WADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]  o_dbg_data
`endif
);

  localparam int NWORDS = 2 ** NB_WADDR;

  logic [NB_DATA-1:0]  ram [NWORDS];

  logic [NB_WADDR-1:0] waddr;
  logic [1:0]          lane;
  logic [1:0]          lane_al;
  logic                is_byte;
  logic                is_half;
  logic                is_word;
  logic                misaligned;
  logic [NB_DATA-1:0]  rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [NB_DATA-1:0]  load_val;
  logic [NB_DATA-1:0]  wr_word;
  logic [3:0]          byte_en;

  assign waddr   = i_ALU_result[NB_WADDR+1:2];
  assign lane    = i_ALU_result[1:0];
  assign is_byte = (i_ctl_MEM_data_width == 2'b00);
  assign is_half = (i_ctl_MEM_data_width == 2'b01);
  assign is_word = i_ctl_MEM_data_width[1];

  assign o_MEM_ALU_result_wire = i_ALU_result;
  assign o_MEM_reg_dest_wire   = i_reg_dest;

`ifdef MEM_DEBUG_PORT_EN
  assign o_dbg_data = ram[i_dbg_addr];
`endif

  // Misaligned accesses are not trapped here; the lane is rounded down and the flag reported.
  always_comb begin
    lane_al    = lane;
    misaligned = 1'b0;
    if (is_half) begin
      lane_al    = {lane[1], 1'b0};
      misaligned = lane[0];
    end else if (is_word) begin
      lane_al    = 2'b00;
      misaligned = (lane != 2'b00);
    end
    if (!(i_ctl_MEM_mem_read || i_ctl_MEM_mem_write)) misaligned = 1'b0;
  end

  always_comb begin
    rd_word  = ram[waddr];
    rd_byte  = rd_word[{lane_al, 3'b000} +: 8];
    rd_half  = rd_word[{lane_al[1], 4'b0000} +: 16];
    load_val = rd_word;
    if (is_byte)
      load_val = i_ctl_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, rd_byte}
                                    : {{(NB_DATA-8){rd_byte[7]}}, rd_byte};
    else if (is_half)
      load_val = i_ctl_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, rd_half}
                                    : {{(NB_DATA-16){rd_half[15]}}, rd_half};
  end

  // Store data is replicated across lanes so byte_en alone selects what lands where.
  always_comb begin
    wr_word = i_data_to_write;
    byte_en = 4'b1111;
    if (is_byte) begin
      wr_word = {4{i_data_to_write[7:0]}};
      byte_en = 4'b0001 << lane_al;
    end else if (is_half) begin
      wr_word = {2{i_data_to_write[15:0]}};
      byte_en = lane_al[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= '0;
      o_ctl_WB_mem_to_reg <= 1'b0;
      o_ctl_WB_reg_write  <= 1'b0;
      o_read_data         <= '0;
      o_ALU_result        <= '0;
      o_reg_dest          <= '0;
      o_misaligned        <= 1'b0;
    end else if (!i_halt) begin
      if (i_ctl_MEM_mem_write) begin
        for (int b = 0; b < 4; b++)
          if (byte_en[b]) ram[waddr][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
      o_ctl_WB_mem_to_reg <= i_ctl_WB_mem_to_reg;
      o_ctl_WB_reg_write  <= i_ctl_WB_reg_write;
      o_read_data         <= i_ctl_MEM_mem_read ? load_val : '0;
      o_ALU_result        <= i_ALU_result;
      o_reg_dest          <= i_reg_dest;
      o_misaligned        <= misaligned;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: loads, stores, alignment, halt, read-before-write, reset.
module tb_memory_access;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_halt;
  logic        i_ctl_MEM_mem_read;
  logic        i_ctl_MEM_mem_write;
  logic        i_ctl_MEM_unsigned;
  logic [1:0]  i_ctl_MEM_data_width;
  logic        i_ctl_WB_mem_to_reg;
  logic        i_ctl_WB_reg_write;
  logic [31:0] i_ALU_result;
  logic [31:0] i_data_to_write;
  logic [4:0]  i_reg_dest;
  logic        o_ctl_WB_mem_to_reg;
  logic        o_ctl_WB_reg_write;
  logic [31:0] o_read_data;
  logic [31:0] o_ALU_result;
  logic [4:0]  o_reg_dest;
  logic        o_misaligned;
  logic [31:0] o_MEM_ALU_result_wire;
  logic [4:0]  o_MEM_reg_dest_wire;
`ifdef MEM_DEBUG_PORT_EN
  logic [7:0]  i_dbg_addr;
  logic [31:0] o_dbg_data;
`endif

  int checks = 0;
  int passed = 0;

  localparam logic [1:0] W_B = 2'b00, W_H = 2'b01, W_W = 2'b10;

  memory_access #(.NB_DATA(32), .NB_WADDR(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_halt(i_halt),
    .i_ctl_MEM_mem_read(i_ctl_MEM_mem_read), .i_ctl_MEM_mem_write(i_ctl_MEM_mem_write),
    .i_ctl_MEM_unsigned(i_ctl_MEM_unsigned), .i_ctl_MEM_data_width(i_ctl_MEM_data_width),
    .i_ctl_WB_mem_to_reg(i_ctl_WB_mem_to_reg), .i_ctl_WB_reg_write(i_ctl_WB_reg_write),
    .i_ALU_result(i_ALU_result), .i_data_to_write(i_data_to_write), .i_reg_dest(i_reg_dest),
    .o_ctl_WB_mem_to_reg(o_ctl_WB_mem_to_reg), .o_ctl_WB_reg_write(o_ctl_WB_reg_write),
    .o_read_data(o_read_data), .o_ALU_result(o_ALU_result), .o_reg_dest(o_reg_dest),
    .o_misaligned(o_misaligned), .o_MEM_ALU_result_wire(o_MEM_ALU_result_wire),
    .o_MEM_reg_dest_wire(o_MEM_reg_dest_wire)
`ifdef MEM_DEBUG_PORT_EN
    , .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
`endif
  );

  // Clock/reset block
  always #5 i_clk = ~i_clk;

  // Driver: apply one EX/MEM bundle, cross one posedge, return 1 time unit after it.
  task automatic drive(input logic rd, input logic wr, input logic uns, input logic [1:0] w,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] dest, input logic halt);
    i_ctl_MEM_mem_read   = rd;
    i_ctl_MEM_mem_write  = wr;
    i_ctl_MEM_unsigned   = uns;
    i_ctl_MEM_data_width = w;
    i_ctl_WB_mem_to_reg  = rd;
    i_ctl_WB_reg_write   = ~wr;
    i_ALU_result         = addr;
    i_data_to_write      = data;
    i_reg_dest           = dest;
    i_halt               = halt;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_halt = 0; i_ctl_MEM_mem_read = 0; i_ctl_MEM_mem_write = 0; i_ctl_MEM_unsigned = 0;
    i_ctl_MEM_data_width = W_W; i_ctl_WB_mem_to_reg = 0; i_ctl_WB_reg_write = 0;
    i_ALU_result = 32'h0; i_data_to_write = 32'h0; i_reg_dest = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_ctl_WB_reg_write = 1; i_ALU_result = 32'h1234; i_reg_dest = 5'd3;
    i_reset = 1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_ctl_WB_mem_to_reg, o_ctl_WB_reg_write, o_read_data, o_ALU_result, o_reg_dest,
         o_misaligned} !== '0)
      $display("FAIL reset_outputs: got rd=%h alu=%h dest=%0d mis=%b wb=%b%b, expected all 0",
               o_read_data, o_ALU_result, o_reg_dest, o_misaligned,
               o_ctl_WB_mem_to_reg, o_ctl_WB_reg_write);
    else passed++;
    i_reset = 0;
    drive(1, 0, 0, W_W, 32'h00, 32'h0, 5'd1, 0);
    checks++;
    if (o_read_data !== 32'h0 || o_misaligned !== 1'b0)
      $display("FAIL reset_lw0: got data=%h mis=%b, expected 00000000/0", o_read_data, o_misaligned);
    else passed++;
    checks++;
    if (o_reg_dest !== 5'd1 || o_ctl_WB_mem_to_reg !== 1'b1 || o_ctl_WB_reg_write !== 1'b1)
      $display("FAIL reset_lw0_ctl: got dest=%0d wb=%b%b, expected 1/11",
               o_reg_dest, o_ctl_WB_mem_to_reg, o_ctl_WB_reg_write);
    else passed++;
  endtask

  task automatic test_byte_loads();
    drive(0, 1, 0, W_W, 32'h10, 32'hA1B2C3D4, 5'd0, 0);
    checks++;
    if (o_read_data !== 32'h0 || o_ALU_result !== 32'h10)
      $display("FAIL store_outputs: got data=%h alu=%h, expected 00000000/00000010",
               o_read_data, o_ALU_result);
    else passed++;
    drive(1, 0, 0, W_B, 32'h11, 32'h0, 5'd4, 0);
    checks++;
    if (o_read_data !== 32'hFFFFFFC3)
      $display("FAIL lb_signed: got %h, expected FFFFFFC3", o_read_data);
    else passed++;
    drive(1, 0, 1, W_B, 32'h13, 32'h0, 5'd5, 0);
    checks++;
    if (o_read_data !== 32'h000000A1 || o_misaligned !== 1'b0)
      $display("FAIL lbu: got data=%h mis=%b, expected 000000A1/0", o_read_data, o_misaligned);
    else passed++;
    drive(1, 0, 1, W_H, 32'h10, 32'h0, 5'd5, 0);
    checks++;
    if (o_read_data !== 32'h0000C3D4)
      $display("FAIL lhu: got %h, expected 0000C3D4", o_read_data);
    else passed++;
  endtask

  task automatic test_half_store();
    drive(0, 1, 0, W_W, 32'h14, 32'hA1B2C3D4, 5'd0, 0);
    drive(0, 1, 0, W_H, 32'h16, 32'h00008765, 5'd0, 0);
    drive(1, 0, 0, W_W, 32'h14, 32'h0, 5'd6, 0);
    checks++;
    if (o_read_data !== 32'h8765C3D4)
      $display("FAIL sh_merge: got %h, expected 8765C3D4", o_read_data);
    else passed++;
    drive(1, 0, 0, W_H, 32'h16, 32'h0, 5'd6, 0);
    checks++;
    if (o_read_data !== 32'hFFFF8765)
      $display("FAIL lh_signed: got %h, expected FFFF8765", o_read_data);
    else passed++;
  endtask

  task automatic test_misaligned();
    drive(1, 0, 0, W_W, 32'h12, 32'h0, 5'd7, 0);
    checks++;
    if (o_misaligned !== 1'b1 || o_read_data !== 32'hA1B2C3D4)
      $display("FAIL lw_misaligned: got mis=%b data=%h, expected 1/A1B2C3D4", o_misaligned, o_read_data);
    else passed++;
    drive(0, 1, 0, W_H, 32'h05, 32'h1234BEEF, 5'd0, 0);
    checks++;
    if (o_misaligned !== 1'b1)
      $display("FAIL sh_misaligned_flag: got %b, expected 1", o_misaligned);
    else passed++;
    drive(1, 0, 0, W_W, 32'h04, 32'h0, 5'd7, 0);
    checks++;
    if (o_read_data !== 32'h0000BEEF || o_misaligned !== 1'b0)
      $display("FAIL sh_misaligned_data: got data=%h mis=%b, expected 0000BEEF/0", o_read_data, o_misaligned);
    else passed++;
    drive(0, 0, 0, W_W, 32'h13, 32'h0, 5'd7, 0);
    checks++;
    if (o_misaligned !== 1'b0 || o_read_data !== 32'h0)
      $display("FAIL no_access_flag: got mis=%b data=%h, expected 0/00000000", o_misaligned, o_read_data);
    else passed++;
  endtask

  task automatic test_halt();
    drive(1, 0, 0, W_W, 32'h10, 32'h0, 5'd7, 0);
    drive(0, 1, 0, W_W, 32'h20, 32'hDEADBEEF, 5'd9, 1);
    checks++;
    if (o_read_data !== 32'hA1B2C3D4 || o_ALU_result !== 32'h10 || o_reg_dest !== 5'd7 ||
        o_ctl_WB_reg_write !== 1'b1)
      $display("FAIL halt_hold: got data=%h alu=%h dest=%0d rw=%b, expected A1B2C3D4/00000010/7/1",
               o_read_data, o_ALU_result, o_reg_dest, o_ctl_WB_reg_write);
    else passed++;
    checks++;
    if (o_MEM_ALU_result_wire !== 32'h20 || o_MEM_reg_dest_wire !== 5'd9)
      $display("FAIL halt_wires: got alu=%h dest=%0d, expected 00000020/9",
               o_MEM_ALU_result_wire, o_MEM_reg_dest_wire);
    else passed++;
    drive(1, 0, 0, W_W, 32'h20, 32'h0, 5'd8, 0);
    checks++;
    if (o_read_data !== 32'h0)
      $display("FAIL halt_no_write: got %h, expected 00000000", o_read_data);
    else passed++;
    drive(0, 1, 0, W_W, 32'h20, 32'hDEADBEEF, 5'd0, 0);
    drive(1, 0, 0, W_W, 32'h20, 32'h0, 5'd8, 0);
    checks++;
    if (o_read_data !== 32'hDEADBEEF)
      $display("FAIL unhalt_write: got %h, expected DEADBEEF", o_read_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 0, W_W, 32'h30, 32'h11111111, 5'd0, 0);
    drive(1, 1, 0, W_W, 32'h30, 32'h22222222, 5'd10, 0);
    checks++;
    if (o_read_data !== 32'h11111111)
      $display("FAIL rw_old_data: got %h, expected 11111111", o_read_data);
    else passed++;
    drive(1, 0, 0, W_W, 32'h30, 32'h0, 5'd10, 0);
    checks++;
    if (o_read_data !== 32'h22222222)
      $display("FAIL rw_new_data: got %h, expected 22222222", o_read_data);
    else passed++;
`ifdef MEM_DEBUG_PORT_EN
    i_dbg_addr = 8'h0C;
    #1;
    checks++;
    if (o_dbg_data !== 32'h22222222)
      $display("FAIL dbg_port: got %h, expected 22222222", o_dbg_data);
    else passed++;
`endif
  endtask

  task automatic test_reset_clears_ram();
    drive(0, 1, 0, W_W, 32'h40, 32'hCAFEF00D, 5'd0, 0);
    i_ALU_result = 32'h44; i_data_to_write = 32'h55AA55AA; i_ctl_MEM_mem_write = 1;
    i_reset = 1;
    @(posedge i_clk);
    #1;
    i_reset = 0;
    drive(1, 0, 0, W_W, 32'h40, 32'h0, 5'd2, 0);
    checks++;
    if (o_read_data !== 32'h0)
      $display("FAIL reset_clears_ram: got %h, expected 00000000", o_read_data);
    else passed++;
    drive(1, 0, 0, W_W, 32'h44, 32'h0, 5'd2, 0);
    checks++;
    if (o_read_data !== 32'h0)
      $display("FAIL reset_over_store: got %h, expected 00000000", o_read_data);
    else passed++;
  endtask

  initial begin
`ifdef MEM_DEBUG_PORT_EN
    i_dbg_addr = 8'h00;
`endif
    test_reset();
    test_byte_loads();
    test_half_store();
    test_misaligned();
    test_halt();
    test_back_to_back();
    test_reset_clears_ram();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
